// File: rtl/if_id_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_if
// Purpose  : Fetch/decode bus bundle between the fetch side and the D stage.
// Revision : 1.0
// ============================================================================
interface if_id_if;
    logic [31:0] pcF;
    logic        inst_reqF;
    logic [31:0] inst_rdata;
    logic        stallD;
    logic        flushD;
    logic        branch_jumpD;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pc_plus4D;
    logic        validD;
    logic        in_delayslotD;
    logic        adelD;

    modport master (
        output pcF, inst_reqF, inst_rdata, stallD, flushD, branch_jumpD,
        input  instrD, pcD, pc_plus4D, validD, in_delayslotD, adelD
    );

    modport slave (
        input  pcF, inst_reqF, inst_rdata, stallD, flushD, branch_jumpD,
        output instrD, pcD, pc_plus4D, validD, in_delayslotD, adelD
    );
endinterface
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Purpose  : IF->D pipeline register with stall hold buffer, flush and
//            delay-slot / fetch-alignment tracking.
// Revision : 1.0
// ============================================================================
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  wire logic   clk,
    input  wire logic   rst,
    if_id_if.slave      bus
);

    typedef enum logic [0:0] {
        ST_DIRECT = 1'b0,
        ST_HELD   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] hold_q,  hold_d;
    logic        valid_q, valid_d;
    logic        ds_q,    ds_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DIRECT;
            pc_q    <= RESET_PC;
            hold_q  <= 32'd0;
            valid_q <= 1'b0;
            ds_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ds_q    <= ds_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        ds_d    = ds_q;
        if (bus.flushD) begin
            valid_d = 1'b0;
            ds_d    = 1'b0;
            state_d = ST_DIRECT;
        end else if (bus.stallD) begin
            // SRAM data is only valid in the first D cycle; latch it then.
            if (state_q == ST_DIRECT && valid_q) begin
                state_d = ST_HELD;
                hold_d  = bus.inst_rdata;
            end
        end else begin
            pc_d    = bus.pcF;
            valid_d = bus.inst_reqF;
            ds_d    = valid_q & bus.branch_jumpD;
            state_d = ST_DIRECT;
        end
    end

    logic w_adel;
    assign w_adel = valid_q & (pc_q[1:0] != 2'b00);

    always_comb begin
        bus.instrD = 32'd0;
        if (valid_q && !w_adel) begin
            bus.instrD = (state_q == ST_HELD) ? hold_q : bus.inst_rdata;
        end
    end

    assign bus.pcD           = pc_q;
    assign bus.pc_plus4D     = pc_q + 32'd4;
    assign bus.validD        = valid_q;
    assign bus.in_delayslotD = ds_q;
    assign bus.adelD         = w_adel;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage
// Purpose  : Directed self-checking bench for if_id_stage.
// Revision : 1.0
// ============================================================================
module tb_if_id_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    if_id_if bus ();

    if_id_stage #(.RESET_PC(32'hbfc00000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pcF = 32'h0; bus.inst_reqF = 1'b1; bus.inst_rdata = 32'hdeadbeef;
        bus.stallD = 1'b0; bus.flushD = 1'b0; bus.branch_jumpD = 1'b0;
        tick(); tick();
        total++;
        if ({bus.pcD, bus.pc_plus4D, bus.instrD, bus.validD, bus.in_delayslotD, bus.adelD}
            !== {32'hbfc00000, 32'hbfc00004, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: got pc=%h p4=%h ins=%h v=%b ds=%b adel=%b want pc=bfc00000 p4=bfc00004 ins=0 v=0 ds=0 adel=0",
                     bus.pcD, bus.pc_plus4D, bus.instrD, bus.validD, bus.in_delayslotD, bus.adelD);
        end
        rst = 1'b0;
    endtask

    task automatic test_seq_fetch();
        bus.inst_reqF = 1'b1;
        bus.pcF = 32'hbfc00000; tick(); bus.inst_rdata = 32'h24080001; #1;
        total++;
        if ({bus.validD, bus.pcD, bus.instrD, bus.pc_plus4D} !== {1'b1, 32'hbfc00000, 32'h24080001, 32'hbfc00004}) begin
            bad++;
            $display("FAIL seq0: got v=%b pc=%h ins=%h p4=%h want v=1 pc=bfc00000 ins=24080001 p4=bfc00004",
                     bus.validD, bus.pcD, bus.instrD, bus.pc_plus4D);
        end
        bus.pcF = 32'hbfc00004; tick(); bus.inst_rdata = 32'h24090002; #1;
        total++;
        if ({bus.validD, bus.pcD, bus.instrD, bus.pc_plus4D, bus.in_delayslotD} !== {1'b1, 32'hbfc00004, 32'h24090002, 32'hbfc00008, 1'b0}) begin
            bad++;
            $display("FAIL seq1: got v=%b pc=%h ins=%h p4=%h ds=%b want v=1 pc=bfc00004 ins=24090002 p4=bfc00008 ds=0",
                     bus.validD, bus.pcD, bus.instrD, bus.pc_plus4D, bus.in_delayslotD);
        end
    endtask

    task automatic test_stall_hold();
        logic [31:0] rd [3] = '{32'hdeadbeef, 32'h12345678, 32'hdeadbeef};
        bus.pcF = 32'hbfc00010; tick(); bus.inst_rdata = 32'h24080001;
        bus.stallD = 1'b1; bus.pcF = 32'hbfc00014;
        for (int i = 0; i < 3; i++) begin
            tick(); bus.inst_rdata = rd[i]; #1;
            total++;
            if ({bus.instrD, bus.pcD, bus.validD} !== {32'h24080001, 32'hbfc00010, 1'b1}) begin
                bad++;
                $display("FAIL stall_hold%0d: got ins=%h pc=%h v=%b want ins=24080001 pc=bfc00010 v=1",
                         i, bus.instrD, bus.pcD, bus.validD);
            end
        end
        bus.stallD = 1'b0;
        tick(); bus.inst_rdata = 32'h24090002; #1;
        total++;
        if ({bus.instrD, bus.pcD} !== {32'h24090002, 32'hbfc00014}) begin
            bad++;
            $display("FAIL stall_release: got ins=%h pc=%h want ins=24090002 pc=bfc00014", bus.instrD, bus.pcD);
        end
        bus.inst_rdata = 32'h11112222; #1;
        total++;
        if (bus.instrD !== 32'h11112222) begin
            bad++;
            $display("FAIL stall_direct: got ins=%h want ins=11112222", bus.instrD);
        end
    endtask

    task automatic test_delay_slot();
        bus.pcF = 32'hbfc00020; tick();
        bus.inst_rdata = 32'h10000003; bus.branch_jumpD = 1'b1;
        bus.pcF = 32'hbfc00024; tick();
        bus.branch_jumpD = 1'b0; bus.inst_rdata = 32'h24080001; #1;
        total++;
        if ({bus.in_delayslotD, bus.pcD} !== {1'b1, 32'hbfc00024}) begin
            bad++;
            $display("FAIL ds_set: got ds=%b pc=%h want ds=1 pc=bfc00024", bus.in_delayslotD, bus.pcD);
        end
        bus.pcF = 32'hbfc00028; tick();
        total++;
        if (bus.in_delayslotD !== 1'b0) begin
            bad++;
            $display("FAIL ds_clear: got ds=%b want ds=0", bus.in_delayslotD);
        end
        // Branch stalled for two cycles before advancing.
        bus.pcF = 32'hbfc00030; tick();
        bus.inst_rdata = 32'h10000003; bus.branch_jumpD = 1'b1; bus.stallD = 1'b1;
        bus.pcF = 32'hbfc00034;
        tick(); bus.inst_rdata = 32'hdeadbeef; #1;
        total++;
        if ({bus.instrD, bus.in_delayslotD} !== {32'h10000003, 1'b0}) begin
            bad++;
            $display("FAIL ds_stalled_beq: got ins=%h ds=%b want ins=10000003 ds=0", bus.instrD, bus.in_delayslotD);
        end
        tick(); bus.stallD = 1'b0;
        tick(); bus.branch_jumpD = 1'b0; bus.inst_rdata = 32'h24090002; #1;
        total++;
        if ({bus.in_delayslotD, bus.pcD, bus.instrD} !== {1'b1, 32'hbfc00034, 32'h24090002}) begin
            bad++;
            $display("FAIL ds_after_stall: got ds=%b pc=%h ins=%h want ds=1 pc=bfc00034 ins=24090002",
                     bus.in_delayslotD, bus.pcD, bus.instrD);
        end
        bus.pcF = 32'hbfc00038; tick();
        total++;
        if (bus.in_delayslotD !== 1'b0) begin
            bad++;
            $display("FAIL ds_after_stall_clear: got ds=%b want ds=0", bus.in_delayslotD);
        end
    endtask

    task automatic test_flush_stall();
        bus.branch_jumpD = 1'b1; bus.pcF = 32'hbfc00040; tick();
        bus.branch_jumpD = 1'b0; bus.inst_rdata = 32'h24080001; bus.stallD = 1'b1;
        tick(); bus.inst_rdata = 32'hdeadbeef; #1;
        total++;
        if ({bus.instrD, bus.in_delayslotD} !== {32'h24080001, 1'b1}) begin
            bad++;
            $display("FAIL flush_setup: got ins=%h ds=%b want ins=24080001 ds=1", bus.instrD, bus.in_delayslotD);
        end
        bus.flushD = 1'b1;
        tick();
        total++;
        if ({bus.validD, bus.instrD, bus.in_delayslotD, bus.pcD} !== {1'b0, 32'h0, 1'b0, 32'hbfc00040}) begin
            bad++;
            $display("FAIL flush_stall: got v=%b ins=%h ds=%b pc=%h want v=0 ins=0 ds=0 pc=bfc00040",
                     bus.validD, bus.instrD, bus.in_delayslotD, bus.pcD);
        end
        bus.flushD = 1'b0; bus.stallD = 1'b0; bus.pcF = 32'hbfc00044;
        tick(); bus.inst_rdata = 32'h24090002; #1;
        total++;
        if ({bus.validD, bus.instrD} !== {1'b1, 32'h24090002}) begin
            bad++;
            $display("FAIL flush_direct: got v=%b ins=%h want v=1 ins=24090002", bus.validD, bus.instrD);
        end
    endtask

    task automatic test_reset_mid_stall();
        bus.pcF = 32'hbfc00050; tick(); bus.inst_rdata = 32'h24080001;
        bus.stallD = 1'b1; tick(); rst = 1'b1; tick();
        total++;
        if ({bus.pcD, bus.validD, bus.instrD, bus.in_delayslotD} !== {32'hbfc00000, 1'b0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid_stall: got pc=%h v=%b ins=%h ds=%b want pc=bfc00000 v=0 ins=0 ds=0",
                     bus.pcD, bus.validD, bus.instrD, bus.in_delayslotD);
        end
        rst = 1'b0; bus.stallD = 1'b0; bus.pcF = 32'hbfc00000;
        tick(); bus.inst_rdata = 32'h24090002; #1;
        total++;
        if (bus.instrD !== 32'h24090002) begin
            bad++;
            $display("FAIL rst_mid_stall_direct: got ins=%h want ins=24090002", bus.instrD);
        end
    endtask

    task automatic test_misaligned();
        bus.pcF = 32'hbfc00002; tick(); bus.inst_rdata = 32'h8c080000; #1;
        total++;
        if ({bus.adelD, bus.instrD, bus.pcD, bus.validD, bus.pc_plus4D} !== {1'b1, 32'h0, 32'hbfc00002, 1'b1, 32'hbfc00006}) begin
            bad++;
            $display("FAIL misaligned: got adel=%b ins=%h pc=%h v=%b p4=%h want adel=1 ins=0 pc=bfc00002 v=1 p4=bfc00006",
                     bus.adelD, bus.instrD, bus.pcD, bus.validD, bus.pc_plus4D);
        end
    endtask

    task automatic test_bubble_wrap();
        bus.inst_reqF = 1'b0; bus.pcF = 32'hbfc00008; tick(); bus.inst_rdata = 32'h24080001; #1;
        total++;
        if ({bus.validD, bus.instrD, bus.adelD, bus.pcD} !== {1'b0, 32'h0, 1'b0, 32'hbfc00008}) begin
            bad++;
            $display("FAIL bubble: got v=%b ins=%h adel=%b pc=%h want v=0 ins=0 adel=0 pc=bfc00008",
                     bus.validD, bus.instrD, bus.adelD, bus.pcD);
        end
        bus.inst_reqF = 1'b1; bus.pcF = 32'hfffffffc; tick(); bus.inst_rdata = 32'h24090002; #1;
        total++;
        if ({bus.pc_plus4D, bus.pcD, bus.instrD} !== {32'h0, 32'hfffffffc, 32'h24090002}) begin
            bad++;
            $display("FAIL wrap: got p4=%h pc=%h ins=%h want p4=00000000 pc=fffffffc ins=24090002",
                     bus.pc_plus4D, bus.pcD, bus.instrD);
        end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_stall_hold();
        test_delay_slot();
        test_flush_stall();
        test_reset_mid_stall();
        test_misaligned();
        test_bubble_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_stage.md
# if_id_stage

Fetch-to-decode pipeline stage of the five-stage MIPS core. Registers the fetch PC, aligns it with the instruction SRAM read data (which returns one cycle after the request), and presents a stable `instrD`/`pcD` pair to the main decoder. Provides a hold buffer for stalls, and flush handling. Also tracks branch-delay-slot status and fetch-address alignment errors for the CP0 exception path.

## Interface
Parameters:
- `RESET_PC`, 32'hbfc00000, value loaded into `pcD` on reset.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pcF`  in  32  PC presented to the instruction SRAM this cycle.
- `inst_reqF`  in  1  a fetch request is issued at `pcF` this cycle.
- `inst_rdata`  in  32  SRAM read data, valid the cycle after its request.
- `stallD`  in  1  hold the D stage (hazard unit).
- `flushD`  in  1  squash the D-stage instruction (exception or eret).
- `branch_jumpD`  in  1  the decoder's branch/j/jal/jr/jalr/bal indication for the current `instrD`.
- `instrD`  out  32  instruction to the decoder.
- `pcD`  out  32  PC of `instrD`.
- `pc_plus4D`  out  32  `pcD + 4`.
- `validD`  out  1  D holds a real instruction.
- `in_delayslotD`  out  1  `instrD` sits in a branch delay slot.
- `adelD`  out  1  fetch address error: `pcD[1:0] != 0`.

## Operation
- D register update, in priority order on each edge:
  - `rst`
  - `flushD`
  - `stallD` (hold)
  - advance.
- Advance:
  - `pcD <= pcF`.
  - `validD <= inst_reqF`.
  - `in_delayslotD <= validD & branch_jumpD`.
- Flush:
  - `validD <= 0`.
  - `in_delayslotD <= 0`.
  - `pcD` keeps its value.
  - Buffer state returns to DIRECT.
- Buffer FSM, two states:
  - DIRECT: `instrD` sources from `inst_rdata`.
  - HELD: `instrD` sources from the 32-bit `hold_q` register.
- FSM transitions:
  - DIRECT → HELD when `stallD & validD & !flushD`; `hold_q <= inst_rdata` on that edge.
  - HELD → DIRECT on any edge with `!stallD` or `flushD`.
  - HELD with `stallD` stays in HELD; `hold_q` is unchanged.
  - DIRECT with `!validD` never enters HELD.
- `instrD` is combinational:
  - 0 if `!validD` or `adelD`.
  - else `hold_q` in HELD.
  - else `inst_rdata`.
- `adelD = validD & (pcD[1:0] != 2'b00)`, combinational.
- `pc_plus4D = pcD + 32'd4`, modulo 2^32 (32'hfffffffc → 0).
- A bubble (`inst_reqF=0` on advance) yields `validD=0` and `instrD=0`, which decodes as sll $0 (nop).
- The branch indication propagates even when the branch itself is stalled: `in_delayslotD` is computed only on the advance edge, from the instruction leaving D.

## Timing
- Reset values:
  - `pcD=RESET_PC`, `pc_plus4D=RESET_PC+4`.
  - `validD=0`, `instrD=0`, `in_delayslotD=0`, `adelD=0`.
  - FSM=DIRECT, `hold_q=0`.
- Latency:
  - Request at `pcF` in cycle t → `pcD`/`instrD` valid in cycle t+1 (zero-wait SRAM).
  - No additional register on `instrD`.
- Stall in the first D cycle: data captured at the end of that cycle. `instrD` stays identical for all stalled cycles even if `inst_rdata` changes.
- Stall release: on the edge where `stallD` falls, the next instruction loads, and `instrD` follows `inst_rdata` in the following cycle.
- `flushD` and `stallD` both high: flush wins; the next cycle has `validD=0`.
- `rst` mid-stall (FSM in HELD): the FSM returns to DIRECT and all outputs take their reset values on that edge.
- Outputs are stable within a cycle except the `inst_rdata` pass-through in DIRECT.

## Test plan
- Reset then sequential fetch:
  - Stimulus: `pcF=bfc00000,bfc00004` with rdata 24080001, 24090002.
  - Response: `pcD`/`instrD` pairs appear one cycle later; `pc_plus4D=bfc00004,bfc00008`; `validD=1`.
- Stall hold:
  - Stimulus: `instrD=24080001`; raise `stallD` for 3 cycles while `inst_rdata` toggles to deadbeef.
  - Response: `instrD` stays 24080001 and `pcD` is constant; after release, the next instruction appears and FSM=DIRECT.
- Delay slot:
  - Stimulus: `instrD=beq` with `branch_jumpD=1`, then advance.
  - Response: the next instruction has `in_delayslotD=1`, and the instruction after it has 0.
  - Repeat with a 2-cycle stall on the beq: same result.
- Flush during stall:
  - Stimulus: `stallD=1` and `flushD=1` on the same edge.
  - Response: `validD=0`, `instrD=0`, `in_delayslotD=0`, FSM=DIRECT.
- Misaligned fetch:
  - Stimulus: `pcF=bfc00002` with rdata 8c080000.
  - Response: `adelD=1`, `instrD=0`, `pcD=bfc00002`.
- Bubble and wrap:
  - Stimulus: `inst_reqF=0` on advance.
  - Response: `validD=0`, `instrD=0`.
  - Stimulus: `pcF=fffffffc`.
  - Response: `pc_plus4D=0`.
